// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and constants for the iterative magnitude-compare controller
package cmp_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
   localparam int SLICE_W = 4;
   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_res_t;
endpackage

// File: rtl/mag4_slice.sv
// mag4_slice: combinational 4-bit cascadable magnitude compare
module mag4_slice
   import cmp_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_lt,
   input  logic               i_eq,
   input  logic               i_gt,
   output logic               o_lt,
   output logic               o_eq,
   output logic               o_gt
);
   logic w_same;
   always_comb begin
      w_same = i_a == i_b;
      o_lt   = (i_a < i_b) | (w_same & i_lt);
      o_eq   = w_same & i_eq;
      o_gt   = (i_a > i_b) | (w_same & i_gt);
   end
endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: compares wide operands one nibble per cycle, MSB nibble first,
// stopping at the first differing nibble.
module cmp_seq_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sgn,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_lt,
   output logic             o_eq,
   output logic             o_gt
);
   localparam int NSLICES = WIDTH / SLICE_W;
   localparam int IW      = NSLICES > 1 ? $clog2(NSLICES) : 1;

   cmp_state_t         r_state, w_state_n;
   logic [WIDTH-1:0]   r_a, r_b;
   logic               r_sgn;
   logic [IW-1:0]      r_idx;
   cmp_res_t           r_res, w_res;
   logic [SLICE_W-1:0] w_na, w_nb;
   logic               w_flip, w_fin;

   // Flipping the sign bit of the top nibble maps two's-complement order onto unsigned order.
   always_comb begin
      w_flip = r_sgn & (r_idx == IW'(NSLICES - 1));
      w_na   = r_a[r_idx*SLICE_W +: SLICE_W] ^ {w_flip, 3'b000};
      w_nb   = r_b[r_idx*SLICE_W +: SLICE_W] ^ {w_flip, 3'b000};
   end

   // Higher nibbles were all equal to reach here, so the cascade is a constant eq.
   mag4_slice u_slice (
      .i_a  (w_na),
      .i_b  (w_nb),
      .i_lt (1'b0),
      .i_eq (1'b1),
      .i_gt (1'b0),
      .o_lt (w_res.lt),
      .o_eq (w_res.eq),
      .o_gt (w_res.gt)
   );

   always_comb begin
      w_fin       = w_res.lt | w_res.gt | (r_idx == '0);
      w_state_n   = r_state;
      o_in_ready  = r_state == IDLE;
      o_out_valid = r_state == DONE;
      o_lt        = r_res.lt;
      o_eq        = r_res.eq;
      o_gt        = r_res.gt;
      case (r_state)
         IDLE:    w_state_n = i_in_valid ? RUN : IDLE;
         RUN:     w_state_n = w_fin ? DONE : RUN;
         DONE:    w_state_n = i_out_ready ? IDLE : DONE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_sgn <= 1'b0;
         r_idx <= '0;
         r_res <= '0;
      end else if (r_state == IDLE && i_in_valid) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_sgn <= i_sgn;
         r_idx <= IW'(NSLICES - 1);
      end else if (r_state == RUN) begin
         if (w_fin) r_res <= w_res;
         else       r_idx <= r_idx - IW'(1);
      end else if (r_state == DONE && i_out_ready) begin
         r_res <= '0;
      end
   end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: scoreboard bench for cmp_seq_ctrl (directed cases plus random traffic)
module tb_cmp_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_in_valid = 1'b0;
   logic        o_in_ready;
   logic [15:0] i_a = '0;
   logic [15:0] i_b = '0;
   logic        i_sgn = 1'b0;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic        o_lt, o_eq, o_gt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] res;
      int         k;
      longint     t0;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   cmp_seq_ctrl #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_sgn       (i_sgn),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_lt        (o_lt),
      .o_eq        (o_eq),
      .o_gt        (o_gt)
   );

   function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
      if (x == y) return 3'b010;
      if (s) return ($signed(x) < $signed(y)) ? 3'b100 : 3'b001;
      return (x < y) ? 3'b100 : 3'b001;
   endfunction

   function automatic int kcalc(input logic [15:0] x, input logic [15:0] y);
      for (int i = 3; i >= 0; i--)
         if (x[i*4 +: 4] != y[i*4 +: 4]) return 4 - i;
      return 4;
   endfunction

   // Presents a pair until accepted; t0 is the time of the acceptance edge.
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic s, output longint t0);
      int n;
      @(negedge clk);
      i_in_valid = 1'b1;
      i_a = x;
      i_b = y;
      i_sgn = s;
      for (n = 0; n < 100 && !o_in_ready; n++) @(negedge clk);
      checks++;
      if (!o_in_ready) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%0b required=1", o_in_ready);
      end
      t0 = $time + 5;
      @(negedge clk);
      i_in_valid = 1'b0;
      i_a = $urandom;
      i_b = $urandom;
      i_sgn = $urandom_range(0, 1);
   endtask

   // Waits for out_valid; t is the sampling time of the first valid cycle.
   task automatic collect(output logic [2:0] r, output longint t, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         if (o_out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      r = {o_lt, o_eq, o_gt};
      t = $time;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", o_in_ready); end
      checks++;
      if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", o_out_valid); end
      checks++;
      if ({o_lt, o_eq, o_gt} !== 3'b000) begin errors++; $display("FAIL reset_result got=%b exp=000", {o_lt, o_eq, o_gt}); end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] ta[5], tb[5];
      logic        ts[5];
      logic [2:0]  tr[5];
      int          tk[5];
      longint      t0, t;
      logic [2:0]  r;
      bit          ok;
      exp_t        e;
      ta = '{16'h1234, 16'h8000, 16'h8000, 16'h12F4, 16'h1A00};
      tb = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h12F5, 16'h1900};
      ts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tr = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b001};
      tk = '{4, 1, 1, 4, 2};
      i_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(ta[i], tb[i], ts[i], t0);
         e.res = tr[i];
         e.k = tk[i];
         e.t0 = t0;
         exp_q.push_back(e);
         collect(r, t, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL dir%0d_timeout out_valid=%0b required=1", i, o_out_valid);
            continue;
         end
         checks++;
         if (r !== e.res) begin errors++; $display("FAIL dir%0d_result got=%b exp=%b", i, r, e.res); end
         checks++;
         if (int'((t - 5 - e.t0) / 10) !== e.k) begin
            errors++;
            $display("FAIL dir%0d_latency got=%0d exp=%0d", i, int'((t - 5 - e.t0) / 10), e.k);
         end
         checks++;
         if (o_in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_busy in_ready=%0b exp=0", i, o_in_ready); end
         @(negedge clk);
         checks++;
         if ({o_out_valid, o_in_ready, o_lt, o_eq, o_gt} !== 5'b01000) begin
            errors++;
            $display("FAIL dir%0d_release got ov/ir/res=%b exp=01000", i, {o_out_valid, o_in_ready, o_lt, o_eq, o_gt});
         end
      end
   endtask

   task automatic test_backpressure();
      longint     t0, t;
      logic [2:0] r;
      bit         ok;
      i_out_ready = 1'b0;
      send(16'h0001, 16'h0000, 1'b0, t0);
      collect(r, t, ok);
      checks++;
      if (!ok || r !== 3'b001) begin errors++; $display("FAIL bp_result got=%b exp=001", r); end
      checks++;
      if (int'((t - 5 - t0) / 10) !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", int'((t - 5 - t0) / 10)); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({o_out_valid, o_in_ready, o_lt, o_eq, o_gt} !== 5'b10001) begin
            errors++;
            $display("FAIL bp_hold%0d got ov/ir/res=%b exp=10001", i, {o_out_valid, o_in_ready, o_lt, o_eq, o_gt});
         end
         if (i < 2) @(negedge clk);
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_out_valid, o_in_ready, o_lt, o_eq, o_gt} !== 5'b01000) begin
         errors++;
         $display("FAIL bp_release got ov/ir/res=%b exp=01000", {o_out_valid, o_in_ready, o_lt, o_eq, o_gt});
      end
   endtask

   task automatic test_reset_mid_run();
      longint     t0, t;
      logic [2:0] r;
      bit         ok;
      i_out_ready = 1'b1;
      send(16'hFFFF, 16'hFFFF, 1'b0, t0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({o_out_valid, o_in_ready, o_lt, o_eq, o_gt} !== 5'b01000) begin
         errors++;
         $display("FAIL rst_mid got ov/ir/res=%b exp=01000", {o_out_valid, o_in_ready, o_lt, o_eq, o_gt});
      end
      send(16'h0003, 16'h0004, 1'b0, t0);
      collect(r, t, ok);
      checks++;
      if (!ok || r !== 3'b100) begin errors++; $display("FAIL rst_after_result got=%b exp=100", r); end
      checks++;
      if (int'((t - 5 - t0) / 10) !== 4) begin errors++; $display("FAIL rst_after_latency got=%0d exp=4", int'((t - 5 - t0) / 10)); end
      @(negedge clk);
   endtask

   task automatic test_random();
      exp_q.delete();
      i_out_ready = 1'b0;
      fork
         begin
            longint      t0;
            logic [15:0] x, y, lm;
            logic        s;
            int          m;
            exp_t        e;
            for (int n = 0; n < 1000; n++) begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               x = 16'($urandom);
               s = 1'($urandom_range(0, 1));
               m = $urandom_range(0, 5);
               if (m == 0) y = x;
               else if (m == 5) y = 16'($urandom);
               else begin
                  lm = (16'h1 << ((m - 1) * 4)) - 16'h1;
                  y = (x & ~lm) ^ (16'($urandom_range(1, 15)) << ((m - 1) * 4));
                  y = (y & ~lm) | (16'($urandom) & lm);
               end
               send(x, y, s, t0);
               e.res = model(x, y, s);
               e.k = kcalc(x, y);
               e.t0 = t0;
               exp_q.push_back(e);
            end
         end
         begin
            int         got = 0;
            bit         pv = 1'b0;
            logic [2:0] r, last = '0;
            exp_t       e;
            for (int c = 0; c < 40000 && got < 1000; c++) begin
               @(negedge clk);
               r = {o_lt, o_eq, o_gt};
               checks++;
               if (o_out_valid ? ($countones(r) != 1) : (r !== 3'b000)) begin
                  errors++;
                  $display("FAIL rnd_onehot ov=%0b got=%b", o_out_valid, r);
               end
               if (o_out_valid && !pv) begin
                  got++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL rnd_unexpected got=%b exp=none", r);
                  end else begin
                     e = exp_q.pop_front();
                     if (r !== e.res) begin errors++; $display("FAIL rnd_result got=%b exp=%b", r, e.res); end
                     checks++;
                     if (int'(($time - 5 - e.t0) / 10) !== e.k) begin
                        errors++;
                        $display("FAIL rnd_latency got=%0d exp=%0d", int'(($time - 5 - e.t0) / 10), e.k);
                     end
                  end
                  last = r;
               end else if (o_out_valid) begin
                  checks++;
                  if (r !== last) begin errors++; $display("FAIL rnd_stable got=%b exp=%b", r, last); end
               end
               pv = o_out_valid;
               i_out_ready = 1'($urandom_range(0, 1));
            end
            checks++;
            if (got != 1000) begin errors++; $display("FAIL rnd_count got=%0d exp=1000", got); end
         end
      join
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
